// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

    // Identifies a writeback producer; also the encoding of the last-grant register.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    localparam int WB_DEFAULT_DEPTH = 2;

endpackage

// File: rtl/wb_fifo.sv
// Per-source write queue: stores {sel, data}, exposes the head and a
// per-entry valid/sel view so the top can build the pending mask.
module wb_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int SELECT_WIDTH = 3,
    parameter int DEPTH        = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_push,
    input  logic [SELECT_WIDTH-1:0]              i_sel,
    input  logic [DATA_WIDTH-1:0]                i_data,
    input  logic                                 i_pop,
    output logic                                 o_full,
    output logic                                 o_empty,
    output logic [SELECT_WIDTH-1:0]              o_head_sel,
    output logic [DATA_WIDTH-1:0]                o_head_data,
    output logic [DEPTH-1:0]                     o_entry_valid,
    output logic [DEPTH-1:0][SELECT_WIDTH-1:0]   o_entry_sel
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][SELECT_WIDTH-1:0] r_sel;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]   r_data;
    logic [PTR_W-1:0]                   r_wr_ptr;
    logic [PTR_W-1:0]                   r_rd_ptr;
    logic [CNT_W-1:0]                   r_count;
    logic                               w_push;
    logic                               w_pop;
    logic [PTR_W-1:0]                   w_off;

    // Full/empty come from the count alone, so a full queue refuses a push
    // even in a cycle where it also pops.
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_head_sel  = r_sel[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_entry_sel = r_sel;

    // Pointer and occupancy bookkeeping; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Payload storage needs no reset: an entry is only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sel[r_wr_ptr]  <= i_sel;
            r_data[r_wr_ptr] <= i_data;
        end
    end

    // Entry i is live when its distance from the read pointer is below the count.
    always_comb begin
        o_entry_valid = '0;
        w_off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off            = PTR_W'(i) - r_rd_ptr;
            o_entry_valid[i] = (CNT_W'(w_off) < r_count);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two buffered producers (ALU, MEM) share one registered
// register-bank write port with alternating priority on ties, and a pending
// mask covers everything queued or currently on the write port.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int  DATA_WIDTH   = 8,
    parameter int  NUM_REG      = 6,
    parameter int  FIFO_DEPTH   = WB_DEFAULT_DEPTH,
    localparam int SELECT_WIDTH = $clog2(NUM_REG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_alu_valid,
    output logic                    o_alu_ready,
    input  logic [SELECT_WIDTH-1:0] i_alu_sel,
    input  logic [DATA_WIDTH-1:0]   i_alu_data,
    input  logic                    i_mem_valid,
    output logic                    o_mem_ready,
    input  logic [SELECT_WIDTH-1:0] i_mem_sel,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    output logic                    o_write_enable,
    output logic [SELECT_WIDTH-1:0] o_write_select,
    output logic [DATA_WIDTH-1:0]   o_write_data,
    output logic                    o_drop,
    output logic [NUM_REG-1:0]      o_pending
);
    // Handshake: a transfer happens on a rising edge where valid && ready;
    // ready depends only on queue occupancy (never on valid) and is low in reset.

    localparam logic [SELECT_WIDTH:0] SEL_LIMIT = (SELECT_WIDTH + 1)'(NUM_REG);

    logic                                    w_alu_full, w_alu_empty;
    logic [SELECT_WIDTH-1:0]                 w_alu_head_sel;
    logic [DATA_WIDTH-1:0]                   w_alu_head_data;
    logic [FIFO_DEPTH-1:0]                   w_alu_ev;
    logic [FIFO_DEPTH-1:0][SELECT_WIDTH-1:0] w_alu_es;
    logic                                    w_mem_full, w_mem_empty;
    logic [SELECT_WIDTH-1:0]                 w_mem_head_sel;
    logic [DATA_WIDTH-1:0]                   w_mem_head_data;
    logic [FIFO_DEPTH-1:0]                   w_mem_ev;
    logic [FIFO_DEPTH-1:0][SELECT_WIDTH-1:0] w_mem_es;

    logic                    w_grant_alu, w_grant_mem, w_grant_any;
    logic [SELECT_WIDTH-1:0] w_grant_sel;
    logic [DATA_WIDTH-1:0]   w_grant_data;
    logic                    w_grant_in_range;
    logic [NUM_REG-1:0]      w_pending;

    src_e                    r_last_grant;
    logic                    r_write_enable;
    logic [SELECT_WIDTH-1:0] r_write_select;
    logic [DATA_WIDTH-1:0]   r_write_data;
    logic                    r_drop;

    assign o_alu_ready = rst && !w_alu_full;
    assign o_mem_ready = rst && !w_mem_full;

    wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .SELECT_WIDTH(SELECT_WIDTH), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst),
        .i_push(i_alu_valid && o_alu_ready), .i_sel(i_alu_sel), .i_data(i_alu_data),
        .i_pop(w_grant_alu),
        .o_full(w_alu_full), .o_empty(w_alu_empty),
        .o_head_sel(w_alu_head_sel), .o_head_data(w_alu_head_data),
        .o_entry_valid(w_alu_ev), .o_entry_sel(w_alu_es)
    );

    wb_fifo #(.DATA_WIDTH(DATA_WIDTH), .SELECT_WIDTH(SELECT_WIDTH), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk(clk), .rst(rst),
        .i_push(i_mem_valid && o_mem_ready), .i_sel(i_mem_sel), .i_data(i_mem_data),
        .i_pop(w_grant_mem),
        .o_full(w_mem_full), .o_empty(w_mem_empty),
        .o_head_sel(w_mem_head_sel), .o_head_data(w_mem_head_data),
        .o_entry_valid(w_mem_ev), .o_entry_sel(w_mem_es)
    );

    // Grant one non-empty head; on a tie the source not granted last time wins.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!w_alu_empty && !w_mem_empty) begin
            if (r_last_grant == SRC_ALU) w_grant_mem = 1'b1;
            else                         w_grant_alu = 1'b1;
        end else if (!w_alu_empty) begin
            w_grant_alu = 1'b1;
        end else if (!w_mem_empty) begin
            w_grant_mem = 1'b1;
        end
    end

    assign w_grant_any      = w_grant_alu || w_grant_mem;
    assign w_grant_sel      = w_grant_mem ? w_mem_head_sel  : w_alu_head_sel;
    assign w_grant_data     = w_grant_mem ? w_mem_head_data : w_alu_head_data;
    assign w_grant_in_range = ({1'b0, w_grant_sel} < SEL_LIMIT);

    // Output stage: load the granted head; out-of-range selects become a drop pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant   <= SRC_ALU;
            r_write_enable <= 1'b0;
            r_write_select <= '0;
            r_write_data   <= '0;
            r_drop         <= 1'b0;
        end else begin
            r_write_enable <= w_grant_any && w_grant_in_range;
            r_drop         <= w_grant_any && !w_grant_in_range;
            if (w_grant_any) begin
                r_last_grant   <= w_grant_mem ? SRC_MEM : SRC_ALU;
                r_write_select <= w_grant_sel;
                r_write_data   <= w_grant_data;
            end
        end
    end

    // Pending mask: any live queue entry or the active write targeting register r.
    // Out-of-range selects never compare equal to r, so they never show up here.
    always_comb begin
        w_pending = '0;
        for (int r = 0; r < NUM_REG; r++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (w_alu_ev[e] && (w_alu_es[e] == SELECT_WIDTH'(r))) w_pending[r] = 1'b1;
                if (w_mem_ev[e] && (w_mem_es[e] == SELECT_WIDTH'(r))) w_pending[r] = 1'b1;
            end
            if (r_write_enable && (r_write_select == SELECT_WIDTH'(r))) w_pending[r] = 1'b1;
        end
    end

    assign o_write_enable = r_write_enable;
    assign o_write_select = r_write_select;
    assign o_write_data   = r_write_data;
    assign o_drop         = r_drop;
    assign o_pending      = w_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a small register-bank model.
module tb_wb_arbiter;

    logic       clk;
    logic       rst;
    logic       i_alu_valid, i_mem_valid;
    logic       o_alu_ready, o_mem_ready;
    logic [2:0] i_alu_sel, i_mem_sel;
    logic [7:0] i_alu_data, i_mem_data;
    logic       o_write_enable;
    logic [2:0] o_write_select;
    logic [7:0] o_write_data;
    logic       o_drop;
    logic [5:0] o_pending;

    logic [7:0] bank [6];

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.DATA_WIDTH(8), .NUM_REG(6), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_sel(i_alu_sel), .i_alu_data(i_alu_data),
        .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
        .i_mem_sel(i_mem_sel), .i_mem_data(i_mem_data),
        .o_write_enable(o_write_enable), .o_write_select(o_write_select),
        .o_write_data(o_write_data), .o_drop(o_drop), .o_pending(o_pending)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model fed by the write port
    always @(posedge clk) begin
        if (rst && o_write_enable && o_write_select < 3'd6) bank[o_write_select] <= o_write_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [2:0] sel, input logic [7:0] data);
        check({tag, "_we"},   32'(o_write_enable), 32'd1);
        check({tag, "_sel"},  32'(o_write_select), 32'(sel));
        check({tag, "_data"}, 32'(o_write_data),   32'(data));
    endtask

    task automatic drive_alu(input logic v, input logic [2:0] sel, input logic [7:0] data);
        i_alu_valid = v;
        i_alu_sel   = sel;
        i_alu_data  = data;
    endtask

    task automatic drive_mem(input logic v, input logic [2:0] sel, input logic [7:0] data);
        i_mem_valid = v;
        i_mem_sel   = sel;
        i_mem_data  = data;
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b0;
        drive_alu(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        drive_mem(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        tick();
        drive_alu(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        drive_mem(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        tick();
        check("rst_we",        32'(o_write_enable), 32'd0);
        check("rst_sel",       32'(o_write_select), 32'd0);
        check("rst_data",      32'(o_write_data),   32'd0);
        check("rst_drop",      32'(o_drop),         32'd0);
        check("rst_pending",   32'(o_pending),      32'd0);
        check("rst_alu_ready", 32'(o_alu_ready),    32'd0);
        check("rst_mem_ready", 32'(o_mem_ready),    32'd0);
        rst = 1'b1;
        drive_alu(1'b0, 3'd0, 8'h00);
        drive_mem(1'b0, 3'd0, 8'h00);
        #1;
        check("rel_alu_ready", 32'(o_alu_ready), 32'd1);
        check("rel_mem_ready", 32'(o_mem_ready), 32'd1);
        tick();
        check("rel_we", 32'(o_write_enable), 32'd0);

        // Single ALU write: sel 2, data AA accepted at edge t
        drive_alu(1'b1, 3'd2, 8'hAA);
        tick();
        drive_alu(1'b0, 3'd0, 8'h00);
        check("single_pend_t",  32'(o_pending),      32'h04);
        check("single_we_t",    32'(o_write_enable), 32'd0);
        tick();
        check_wr("single_t1", 3'd2, 8'hAA);
        check("single_pend_t1", 32'(o_pending),      32'h04);
        tick();
        check("single_we_t2",   32'(o_write_enable), 32'd0);
        check("single_pend_t2", 32'(o_pending),      32'h00);
        check("single_bank2",   32'(bank[2]),        32'hAA);

        // Simultaneous first requests: MEM wins the first tie
        drive_alu(1'b1, 3'd1, 8'hBB);
        drive_mem(1'b1, 3'd3, 8'hCC);
        tick();
        drive_alu(1'b0, 3'd0, 8'h00);
        drive_mem(1'b0, 3'd0, 8'h00);
        check("sim_pend", 32'(o_pending), 32'h0A);
        tick();
        check_wr("sim_first_mem", 3'd3, 8'hCC);
        check("sim_pend2", 32'(o_pending), 32'h0A);
        tick();
        check_wr("sim_second_alu", 3'd1, 8'hBB);
        tick();
        check("sim_idle", 32'(o_write_enable), 32'd0);

        // Streaming from both sources alternates M0 A0 M1 A1
        drive_alu(1'b1, 3'd0, 8'h10);
        drive_mem(1'b1, 3'd4, 8'h20);
        tick();
        drive_alu(1'b1, 3'd0, 8'h11);
        drive_mem(1'b1, 3'd4, 8'h21);
        tick();
        drive_alu(1'b0, 3'd0, 8'h00);
        drive_mem(1'b0, 3'd0, 8'h00);
        check_wr("alt_m0", 3'd4, 8'h20);
        check("alt_pend", 32'(o_pending), 32'h11);
        tick();
        check_wr("alt_a0", 3'd0, 8'h10);
        tick();
        check_wr("alt_m1", 3'd4, 8'h21);
        tick();
        check_wr("alt_a1", 3'd0, 8'h11);
        tick();
        check("alt_idle", 32'(o_write_enable), 32'd0);

        // Backpressure: three ALU requests while MEM competes for grants
        drive_alu(1'b1, 3'd5, 8'h30);
        drive_mem(1'b1, 3'd3, 8'h40);
        tick();
        drive_alu(1'b1, 3'd5, 8'h31);
        drive_mem(1'b1, 3'd3, 8'h41);
        tick();
        drive_alu(1'b1, 3'd5, 8'h32);
        drive_mem(1'b0, 3'd0, 8'h00);
        check_wr("bp_m2", 3'd3, 8'h40);
        check("bp_ready_full", 32'(o_alu_ready), 32'd0);
        tick();
        check_wr("bp_x0", 3'd5, 8'h30);
        check("bp_ready_after_pop", 32'(o_alu_ready), 32'd1);
        tick();
        drive_alu(1'b0, 3'd0, 8'h00);
        check_wr("bp_m3", 3'd3, 8'h41);
        check("bp_ready_full2", 32'(o_alu_ready), 32'd0);
        tick();
        check_wr("bp_x1", 3'd5, 8'h31);
        tick();
        check_wr("bp_x2", 3'd5, 8'h32);
        tick();
        check("bp_idle", 32'(o_write_enable), 32'd0);

        // Out-of-range select on MEM, then a normal MEM write
        drive_mem(1'b1, 3'd7, 8'hCC);
        tick();
        check("oor_pend_q", 32'(o_pending), 32'h00);
        drive_mem(1'b1, 3'd1, 8'hDD);
        tick();
        drive_mem(1'b0, 3'd0, 8'h00);
        check("oor_drop", 32'(o_drop),         32'd1);
        check("oor_we",   32'(o_write_enable), 32'd0);
        check("oor_pend", 32'(o_pending),      32'h02);
        tick();
        check("oor_drop_clr", 32'(o_drop), 32'd0);
        check_wr("oor_next", 3'd1, 8'hDD);
        tick();
        check("oor_idle",  32'(o_write_enable), 32'd0);
        check("oor_bank1", 32'(bank[1]),        32'hDD);

        // Reset mid-operation with entries queued on both sources
        drive_alu(1'b1, 3'd0, 8'h50);
        drive_mem(1'b1, 3'd2, 8'h60);
        tick();
        drive_alu(1'b1, 3'd0, 8'h51);
        drive_mem(1'b1, 3'd2, 8'h61);
        tick();
        drive_alu(1'b0, 3'd0, 8'h00);
        drive_mem(1'b0, 3'd0, 8'h00);
        check("mid_pend_before", 32'(o_pending), 32'h05);
        check_wr("mid_a0", 3'd0, 8'h50);
        rst = 1'b0;
        #1;
        check("mid_rst_pend",  32'(o_pending),      32'h00);
        check("mid_rst_we",    32'(o_write_enable), 32'd0);
        check("mid_rst_ready", 32'(o_alu_ready),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_post_we",   32'(o_write_enable), 32'd0);
            check("mid_post_drop", 32'(o_drop),         32'd0);
            check("mid_post_pend", 32'(o_pending),      32'h00);
        end
        check("mid_post_ready", 32'(o_mem_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
